// File: rtl/data_deserializer.sv
// Serial-to-parallel receiver: synchronizes an external bit clock and data line, assembles MSB-first words.
// Latency SYNC_STAGES+1..+2 clk from the completing serial edge; a word completing against a stalled output is dropped (overrun).
module data_deserializer #(
    parameter int BIT_DEPTH    = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_clk_in,
    input  logic                 ser_data_in,
    output logic [BIT_DEPTH-1:0] output_tdata,
    output logic                 output_tvalid,
    input  logic                 output_tready,
    output logic                 overrun,
    output logic                 frame_error
);

    localparam int CNT_W  = $clog2(BIT_DEPTH + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int FILL_W = $clog2(SYNC_STAGES + 2);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic [FILL_W-1:0]      r_fill_cnt;
    logic [BIT_DEPTH-2:0]   r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [IDLE_W-1:0]      r_idle_cnt;

    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_fill_done;
    logic                   w_edge;
    logic                   w_last_bit;
    logic                   w_out_free;
    logic [BIT_DEPTH-1:0]   w_next_word;

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];
    // The chains clear to 0 on reset; hold off edge detection until they have
    // refilled, so a line held high across reset is not mistaken for an edge.
    assign w_fill_done = (r_fill_cnt == FILL_W'(SYNC_STAGES + 1));
    assign w_edge      = w_fill_done & w_clk_s & ~r_clk_prev;
    assign w_last_bit  = (r_bit_cnt == CNT_W'(BIT_DEPTH - 1));
    assign w_out_free  = ~output_tvalid | output_tready;
    assign w_next_word = {r_shift, w_dat_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_clk_sync    <= '0;
            r_dat_sync    <= '0;
            r_clk_prev    <= 1'b1;
            r_fill_cnt    <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_idle_cnt    <= '0;
            output_tdata  <= '0;
            output_tvalid <= 1'b0;
            overrun       <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ser_clk_in};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], ser_data_in};
            r_clk_prev  <= w_clk_s;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
            if (!w_fill_done) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end

            if (output_tvalid && output_tready) begin
                output_tvalid <= 1'b0;
            end

            if (w_edge) begin
                r_shift    <= w_next_word[BIT_DEPTH-2:0];
                r_idle_cnt <= '0;
                if (w_last_bit) begin
                    r_bit_cnt <= '0;
                    r_state   <= ST_IDLE;
                    // Load wins over the clear above when the slot frees this cycle.
                    if (w_out_free) begin
                        output_tdata  <= w_next_word;
                        output_tvalid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_state   <= ST_SHIFT;
                end
            end else if (r_state == ST_SHIFT) begin
                if (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                    frame_error <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_idle_cnt  <= '0;
                    r_state     <= ST_IDLE;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_deserializer.sv
// Directed bench for data_deserializer: vector table for plain words, hand-written sequences for stall, timeout and reset cases.
module tb_data_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ser_clk_in;
    logic        ser_data_in;
    logic        output_tready;
    logic [15:0] output_tdata;
    logic        output_tvalid;
    logic        overrun;
    logic        frame_error;

    data_deserializer #(
        .BIT_DEPTH   (16),
        .SYNC_STAGES (2),
        .IDLE_TIMEOUT(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ser_clk_in   (ser_clk_in),
        .ser_data_in  (ser_data_in),
        .output_tdata (output_tdata),
        .output_tvalid(output_tvalid),
        .output_tready(output_tready),
        .overrun      (overrun),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] acc_q[$];
    int          ovr_cnt  = 0;
    int          fe_cnt   = 0;
    int          vld_cyc  = 0;
    int          stab_err = 0;
    logic        p_vld = 1'b0;
    logic        p_rdy = 1'b0;
    logic [15:0] p_dat = '0;

    // Observe on the falling edge; inputs change 2ns after the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (output_tvalid && output_tready) acc_q.push_back(output_tdata);
            if (overrun) ovr_cnt++;
            if (frame_error) fe_cnt++;
            if (output_tvalid) vld_cyc++;
            if (p_vld && !p_rdy && (!output_tvalid || output_tdata !== p_dat)) stab_err++;
        end
        p_vld = output_tvalid && !rst;
        p_rdy = output_tready;
        p_dat = output_tdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        ser_data_in = b;
        ser_clk_in  = 1'b0;
        tick(4);
        ser_clk_in  = 1'b1;
        tick(4);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    function automatic logic [31:0] last_acc();
        if (acc_q.size() == 0) return 32'hDEAD0000;
        return {16'h0, acc_q[acc_q.size()-1]};
    endfunction

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_dat;
        int          exp_vld_cyc;
    } vec_t;

    vec_t vecs[5];
    int   a0, o0, f0, v0;

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 1};
        vecs[1] = '{16'h0000, 16'h0000, 1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1};
        vecs[3] = '{16'h8001, 16'h8001, 1};
        vecs[4] = '{16'h5A5A, 16'h5A5A, 1};

        rst = 1'b1; ser_clk_in = 1'b0; ser_data_in = 1'b0; output_tready = 1'b1;
        tick(4);
        chk("rst_tdata", {16'h0, output_tdata}, 32'h0);
        chk("rst_tvalid", {31'h0, output_tvalid}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_frame_error", {31'h0, frame_error}, 32'h0);
        rst = 1'b0;
        tick(5);

        for (int k = 0; k < 5; k++) begin
            a0 = acc_q.size(); o0 = ovr_cnt; f0 = fe_cnt; v0 = vld_cyc;
            send_word(vecs[k].word);
            tick(8);
            chk($sformatf("vec%0d_count", k), acc_q.size() - a0, 1);
            chk($sformatf("vec%0d_data", k), last_acc(), {16'h0, vecs[k].exp_dat});
            chk($sformatf("vec%0d_vld_cycles", k), vld_cyc - v0, vecs[k].exp_vld_cyc);
            chk($sformatf("vec%0d_pulses", k), (ovr_cnt - o0) + (fe_cnt - f0), 0);
        end

        // Overrun: second word completes against a stalled output.
        output_tready = 1'b0;
        a0 = acc_q.size(); o0 = ovr_cnt;
        send_word(16'h1111);
        tick(8);
        chk("ovr_hold_vld", {31'h0, output_tvalid}, 32'h1);
        chk("ovr_hold_dat", {16'h0, output_tdata}, 32'h1111);
        send_word(16'h2222);
        tick(8);
        chk("ovr_pulse", ovr_cnt - o0, 1);
        chk("ovr_kept_dat", {16'h0, output_tdata}, 32'h1111);
        output_tready = 1'b1;
        tick(3);
        chk("ovr_accept_count", acc_q.size() - a0, 1);
        chk("ovr_accept_dat", last_acc(), 32'h1111);
        chk("ovr_drained", {31'h0, output_tvalid}, 32'h0);

        // Timeout: five bits then silence.
        a0 = acc_q.size(); f0 = fe_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        tick(80);
        chk("to_frame_error", fe_cnt - f0, 1);
        chk("to_no_word", acc_q.size() - a0, 0);
        send_word(16'h1234);
        tick(8);
        chk("to_next_word", last_acc(), 32'h1234);
        chk("to_single_fe", fe_cnt - f0, 1);

        // Simultaneous accept and load: ready asserted in the completion cycle.
        output_tready = 1'b0;
        o0 = ovr_cnt;
        send_word(16'hCAFE);
        tick(8);
        a0 = acc_q.size();
        for (int i = 15; i >= 1; i--) send_bit(1'(16'hBEEF >> i));
        ser_data_in = 1'b1;
        ser_clk_in  = 1'b0;
        tick(4);
        ser_clk_in  = 1'b1;
        tick(2);
        output_tready = 1'b1;
        tick(1);
        output_tready = 1'b0;
        chk("sim_accept_dat", last_acc(), 32'hCAFE);
        chk("sim_accept_count", acc_q.size() - a0, 1);
        chk("sim_vld_stays", {31'h0, output_tvalid}, 32'h1);
        chk("sim_new_dat", {16'h0, output_tdata}, 32'hBEEF);
        tick(4);
        chk("sim_no_overrun", ovr_cnt - o0, 0);
        output_tready = 1'b1;
        tick(3);
        chk("sim_beef_out", last_acc(), 32'hBEEF);

        // Reset mid-word with the serial clock left high.
        for (int i = 0; i < 9; i++) send_bit(1'(i & 1));
        rst = 1'b1;
        tick(3);
        chk("mid_rst_tdata", {16'h0, output_tdata}, 32'h0);
        chk("mid_rst_tvalid", {31'h0, output_tvalid}, 32'h0);
        chk("mid_rst_pulses", {30'h0, overrun, frame_error}, 32'h0);
        rst = 1'b0;
        a0 = acc_q.size(); f0 = fe_cnt;
        tick(90);
        chk("mid_rst_no_fe", fe_cnt - f0, 0);
        chk("mid_rst_no_word", acc_q.size() - a0, 0);
        send_word(16'h00FF);
        tick(8);
        chk("mid_rst_next_word", last_acc(), 32'h00FF);
        chk("mid_rst_count", acc_q.size() - a0, 1);

        chk("stall_stability", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_deserializer.md
DATA_DESERIALIZER -- requirements
Module: data_deserializer

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 16: bits per received word.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on each serial input (legal range 2..4).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 64: clk cycles without a serial clock edge before a partial word is abandoned.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ser_clk_in  input  1  serial bit clock (asynchronous to clk).
REQ-007 SHALL have port ser_data_in  input  1  serial data, MSB first, valid at ser_clk_in rising edge.
REQ-008 SHALL have port output_tdata  output  BIT_DEPTH  received word.
REQ-009 SHALL have port output_tvalid  output  1  word available.
REQ-010 SHALL have port output_tready  input  1  downstream accepts word.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: completed word dropped.
REQ-012 SHALL have port frame_error  output  1  one-cycle pulse: partial word discarded on timeout.

Function
REQ-013 SHALL pass ser_clk_in and ser_data_in through identical SYNC_STAGES-deep flop chains so both stay cycle-aligned.
REQ-014 SHALL detect a serial edge when the synchronized clock is 1 and its previous-cycle value is 0; the previous-value flop resets to 1, so a line held high at reset release produces no edge.
REQ-015 SHALL, on each detected edge, shift the synchronized data bit into the LSB of a BIT_DEPTH shift register (MSB first on the wire) and increment a bit counter.
REQ-016 SHALL use a two-state FSM: IDLE (bit counter 0) -> SHIFT on first edge; SHIFT -> IDLE on the BIT_DEPTH-th edge (word complete) or on timeout.
REQ-017 SHALL, on word completion, load output_tdata and set output_tvalid in the cycle after the completing edge is detected, if the output register is empty or being handshaken that same cycle.
REQ-018 SHALL keep output_tdata and output_tvalid stable while output_tvalid=1 and output_tready=0.
REQ-019 SHALL clear output_tvalid the cycle after output_tvalid & output_tready, unless a new word loads in that same cycle (REQ-017), in which case output_tvalid stays 1 with the new data and no overrun.
REQ-020 SHALL, if a word completes while output_tvalid=1 and output_tready=0, discard the new word, keep the held word, and pulse overrun for one cycle.
REQ-021 SHALL count clk cycles since the last detected edge while in SHIFT; on reaching IDLE_TIMEOUT, SHALL clear the bit counter, return to IDLE, and pulse frame_error for one cycle.
REQ-022 SHALL reset the idle counter on every detected edge and hold it at 0 in IDLE; no frame_error in IDLE.
REQ-023 SHALL support serial clock high and low phases each at least SYNC_STAGES+1 clk cycles; faster serial clocks are out of spec.
REQ-024 SHALL produce latency from the completing ser_clk_in rising edge to output_tvalid of SYNC_STAGES+2 clk cycles (±1 for synchronizer phase).

Reset
REQ-025 SHALL, while rst=1, drive output_tdata=0, output_tvalid=0, overrun=0, frame_error=0; clear shift register, bit counter, idle counter, and synchronizer flops to 0 (edge previous-value flop to 1); enter IDLE.
REQ-026 SHALL, on rst asserted mid-word, discard the partial word with no frame_error; the first post-reset edge starts a new word.

Verification
REQ-027 SHALL verify: 0xA5C3 sent MSB first, ser_clk period 8 clk, tready=1 -> output_tdata=0xA5C3, tvalid high exactly 1 cycle, no pulses.
REQ-028 SHALL verify: tready=0, words 0x1111 then 0x2222 -> overrun pulses once at 0x2222 completion; tdata holds 0x1111 until tready=1; 0x2222 never appears.
REQ-029 SHALL verify: 5 bits then 64 idle cycles -> frame_error pulses once; next word 0x1234 -> output 0x1234.
REQ-030 SHALL verify: tready asserted in the same cycle 0xBEEF completes while 0xCAFE is held -> 0xCAFE accepted, tvalid stays 1 with 0xBEEF, overrun=0.
REQ-031 SHALL verify: rst pulsed after 9 bits with ser_clk_in high -> all outputs 0, no frame_error, no spurious edge; next 16 bits 0x00FF -> output 0x00FF.
